// File: rtl/exe_div_seq_pkg.sv
// rtl/exe_div_seq_pkg.sv - shared constants and state encoding for the EXE divide sequencer
// Reset level, register-address width and FSM encodings used by exe_div_seq.
package exe_div_seq_pkg;

  localparam logic RST_ENABLE = 1'b0;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/exe_div_seq_div_iter_step.sv
// rtl/exe_div_seq_div_iter_step.sv - one combinational radix-2 restoring divide step
// Shifts {rem, quo} left by one and subtracts the divisor when the trial stays non-negative.
module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // The shifted partial remainder can reach 2*|b|-1, hence the extra top bit.
  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  assign rem_o   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_o   = {quo_i[DATA_W-2:0], ~trial[DATA_W]};

endmodule

// File: rtl/exe_div_seq.sv
// rtl/exe_div_seq.sv - multi-cycle RV32M divide sequencer attached to the EXE stage
// Holds the pipeline while a restoring divider iterates, then presents the result until acked.
module exe_div_seq
  import exe_div_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk_i_DIV,
  input  logic                  rst_i_DIV,
  input  logic                  start_i_DIV,
  input  logic                  signed_i_DIV,
  input  logic                  rem_sel_i_DIV,
  input  logic [DATA_W-1:0]     dividend_i_DIV,
  input  logic [DATA_W-1:0]     divisor_i_DIV,
  input  logic [REG_ADDR_W-1:0] wt_addr_i_DIV,
  input  logic                  cancel_i_DIV,
  input  logic                  ack_i_DIV,
  output logic [DATA_W-1:0]     result_o_DIV,
  output logic [REG_ADDR_W-1:0] wt_addr_o_DIV,
  output logic                  valid_o_DIV,
  output logic                  busy_o_DIV,
  output logic                  stall_o_DIV
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rem_q;
  logic [DATA_W-1:0]     quo_q;
  logic [DATA_W-1:0]     b_abs_q;
  logic [DATA_W-1:0]     result_q;
  logic [REG_ADDR_W-1:0] wt_addr_q;
  logic                  rem_sel_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;

  logic                  accept;
  logic                  div_zero;
  logic                  sgn_ovf;
  logic [DATA_W-1:0]     a_abs;
  logic [DATA_W-1:0]     b_abs;
  logic [DATA_W-1:0]     step_rem;
  logic [DATA_W-1:0]     step_quo;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  assign accept   = (state_q == DIV_IDLE) && start_i_DIV && !cancel_i_DIV;
  assign div_zero = (divisor_i_DIV == '0);
  assign sgn_ovf  = signed_i_DIV && (dividend_i_DIV == INT_MIN) && (divisor_i_DIV == '1);
  assign a_abs    = (signed_i_DIV && dividend_i_DIV[DATA_W-1]) ? -dividend_i_DIV : dividend_i_DIV;
  assign b_abs    = (signed_i_DIV && divisor_i_DIV[DATA_W-1])  ? -divisor_i_DIV  : divisor_i_DIV;

  div_iter_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (b_abs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Sign fix-up is applied to the last step's output so DONE sees the final value.
  assign quo_fix = neg_quo_q ? -step_quo : step_quo;
  assign rem_fix = neg_rem_q ? -step_rem : step_rem;

  always_ff @(posedge clk_i_DIV) begin
    if (rst_i_DIV == RST_ENABLE) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = (div_zero || sgn_ovf) ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (cnt_q == CNT_LAST) state_d = DIV_DONE;
      DIV_DONE: if (ack_i_DIV) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (cancel_i_DIV) state_d = DIV_IDLE;
  end

  always_comb begin
    valid_o_DIV = 1'b0;
    busy_o_DIV  = 1'b0;
    stall_o_DIV = 1'b0;
    case (state_q)
      DIV_IDLE: stall_o_DIV = accept;
      DIV_RUN: begin
        busy_o_DIV  = 1'b1;
        stall_o_DIV = 1'b1;
      end
      DIV_DONE: begin
        busy_o_DIV  = 1'b1;
        valid_o_DIV = 1'b1;
        stall_o_DIV = !ack_i_DIV;
      end
      default: ;
    endcase
    if (rst_i_DIV == RST_ENABLE) stall_o_DIV = 1'b0;
  end

  always_ff @(posedge clk_i_DIV) begin
    if (rst_i_DIV == RST_ENABLE) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      b_abs_q   <= '0;
      result_q  <= '0;
      wt_addr_q <= ZERO_REG_ADDR;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_abs;
            b_abs_q   <= b_abs;
            wt_addr_q <= wt_addr_i_DIV;
            rem_sel_q <= rem_sel_i_DIV;
            neg_quo_q <= signed_i_DIV && (dividend_i_DIV[DATA_W-1] ^ divisor_i_DIV[DATA_W-1]);
            neg_rem_q <= signed_i_DIV && dividend_i_DIV[DATA_W-1];
            if (div_zero) begin
              result_q <= rem_sel_i_DIV ? dividend_i_DIV : '1;
            end else if (sgn_ovf) begin
              result_q <= rem_sel_i_DIV ? '0 : INT_MIN;
            end
          end
        end
        DIV_RUN: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          // Saturate rather than wrap so a stray extra RUN cycle cannot restart the count.
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= rem_sel_q ? rem_fix : quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o_DIV  = result_q;
  assign wt_addr_o_DIV = wt_addr_q;

endmodule

// File: tb/tb_exe_div_seq.sv
// tb/tb_exe_div_seq.sv - scoreboard bench for exe_div_seq
// Expected results are queued at request time and popped when valid rises.
module tb_exe_div_seq;

  logic        clk_i_DIV = 1'b0;
  logic        rst_i_DIV;
  logic        start_i_DIV;
  logic        signed_i_DIV;
  logic        rem_sel_i_DIV;
  logic [31:0] dividend_i_DIV;
  logic [31:0] divisor_i_DIV;
  logic [4:0]  wt_addr_i_DIV;
  logic        cancel_i_DIV;
  logic        ack_i_DIV;
  logic [31:0] result_o_DIV;
  logic [4:0]  wt_addr_o_DIV;
  logic        valid_o_DIV;
  logic        busy_o_DIV;
  logic        stall_o_DIV;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] sb_q[$];

  exe_div_seq dut (
    .clk_i_DIV      (clk_i_DIV),
    .rst_i_DIV      (rst_i_DIV),
    .start_i_DIV    (start_i_DIV),
    .signed_i_DIV   (signed_i_DIV),
    .rem_sel_i_DIV  (rem_sel_i_DIV),
    .dividend_i_DIV (dividend_i_DIV),
    .divisor_i_DIV  (divisor_i_DIV),
    .wt_addr_i_DIV  (wt_addr_i_DIV),
    .cancel_i_DIV   (cancel_i_DIV),
    .ack_i_DIV      (ack_i_DIV),
    .result_o_DIV   (result_o_DIV),
    .wt_addr_o_DIV  (wt_addr_o_DIV),
    .valid_o_DIV    (valid_o_DIV),
    .busy_o_DIV     (busy_o_DIV),
    .stall_o_DIV    (stall_o_DIV)
  );

  always #5 clk_i_DIV = ~clk_i_DIV;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i_DIV);
    #1;
  endtask

  function automatic logic [31:0] model(input bit sg, input bit rs, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sg) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return rs ? r : q;
  endfunction

  task automatic do_op(input bit sg, input bit rs, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input int ack_dly, input bit poke_run, input bit ack_start);
    int lat, n, scnt;
    logic [36:0] e;
    logic [31:0] held;
    lat = (b == 32'h0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    sb_q.push_back({wa, model(sg, rs, a, b)});
    signed_i_DIV   = sg;
    rem_sel_i_DIV  = rs;
    dividend_i_DIV = a;
    divisor_i_DIV  = b;
    wt_addr_i_DIV  = wa;
    start_i_DIV    = 1'b1;
    #1;
    chk("stall_on_start", {31'b0, stall_o_DIV}, 32'd1);
    scnt = stall_o_DIV ? 1 : 0;
    tick();
    start_i_DIV = 1'b0;
    n = 1;
    while (!valid_o_DIV && n < 100) begin
      if (stall_o_DIV) scnt++;
      start_i_DIV = poke_run && (n == 5);
      dividend_i_DIV = (poke_run && n == 5) ? (a ^ 32'h5A5A_5A5A) : a;
      tick();
      n++;
    end
    start_i_DIV    = 1'b0;
    dividend_i_DIV = a;
    chk("latency", n, lat);
    if (stall_o_DIV) scnt++;
    e = sb_q.pop_front();
    chk("valid", {31'b0, valid_o_DIV}, 32'd1);
    chk("result", result_o_DIV, e[31:0]);
    chk("wt_addr", {27'b0, wt_addr_o_DIV}, {27'b0, e[36:32]});
    held = result_o_DIV;
    repeat (ack_dly) begin
      tick();
      if (stall_o_DIV) scnt++;
      chk("hold_result", result_o_DIV, held);
      chk("hold_valid", {31'b0, valid_o_DIV}, 32'd1);
    end
    chk("stall_cycles", scnt, lat + 1 + ack_dly);
    ack_i_DIV   = 1'b1;
    start_i_DIV = ack_start;
    #1;
    chk("stall_on_ack", {31'b0, stall_o_DIV}, 32'd0);
    tick();
    ack_i_DIV   = 1'b0;
    start_i_DIV = 1'b0;
    #1;
    chk("idle_after_ack", {30'b0, valid_o_DIV, busy_o_DIV}, 32'd0);
  endtask

  initial begin
    int quiet;
    rst_i_DIV      = 1'b0;
    start_i_DIV    = 1'b0;
    signed_i_DIV   = 1'b0;
    rem_sel_i_DIV  = 1'b0;
    dividend_i_DIV = 32'h0;
    divisor_i_DIV  = 32'h0;
    wt_addr_i_DIV  = 5'd0;
    cancel_i_DIV   = 1'b0;
    ack_i_DIV      = 1'b0;
    repeat (3) tick();
    rst_i_DIV = 1'b1;
    tick();
    chk("rst_state", {27'b0, wt_addr_o_DIV, valid_o_DIV, busy_o_DIV, stall_o_DIV}, 32'd0);
    chk("rst_result", result_o_DIV, 32'd0);

    do_op(1'b0, 1'b0, 32'd100, 32'd7, 5'd3, 0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd4, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, -32'sd100, 32'd7, 5'd5, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, -32'sd100, 32'd7, 5'd6, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 32'd7, -32'sd2, 5'd7, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 32'd7, -32'sd2, 5'd8, 0, 1'b0, 1'b0);
    do_op(1'b0, 1'b0, 32'h1234, 32'h0, 5'd9, 0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'h1234, 32'h0, 5'd10, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 32'hF000_0001, 32'h0, 5'd11, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 1'b0, 1'b0);
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1235, 5'd15, 5, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 32'h7654_3210, 32'hFFFF_FF13, 5'd16, 0, 1'b1, 1'b0);
    do_op(1'b0, 1'b0, 32'd999, 32'd10, 5'd17, 0, 1'b0, 1'b1);

    // Cancel on the tenth RUN cycle, then check nothing ever appears.
    signed_i_DIV   = 1'b0;
    rem_sel_i_DIV  = 1'b0;
    dividend_i_DIV = 32'd1000;
    divisor_i_DIV  = 32'd3;
    wt_addr_i_DIV  = 5'd20;
    start_i_DIV    = 1'b1;
    tick();
    start_i_DIV = 1'b0;
    repeat (9) tick();
    cancel_i_DIV = 1'b1;
    tick();
    cancel_i_DIV = 1'b0;
    #1;
    chk("cancel_idle", {29'b0, valid_o_DIV, busy_o_DIV, stall_o_DIV}, 32'd0);
    quiet = 0;
    repeat (40) begin
      tick();
      if (!valid_o_DIV && !stall_o_DIV) quiet++;
    end
    chk("cancel_quiet", quiet, 40);
    do_op(1'b0, 1'b0, 32'd20, 32'd3, 5'd21, 0, 1'b0, 1'b0);

    // cancel beats start in IDLE
    start_i_DIV  = 1'b1;
    cancel_i_DIV = 1'b1;
    #1;
    chk("cancel_start_stall", {31'b0, stall_o_DIV}, 32'd0);
    tick();
    start_i_DIV  = 1'b0;
    cancel_i_DIV = 1'b0;
    #1;
    chk("cancel_start_idle", {31'b0, busy_o_DIV}, 32'd0);

    // Reset pulse mid-RUN
    dividend_i_DIV = 32'd50;
    divisor_i_DIV  = 32'd5;
    wt_addr_i_DIV  = 5'd25;
    start_i_DIV    = 1'b1;
    tick();
    start_i_DIV = 1'b0;
    repeat (8) tick();
    rst_i_DIV = 1'b0;
    #1;
    chk("rst_stall_forced", {31'b0, stall_o_DIV}, 32'd0);
    tick();
    rst_i_DIV = 1'b1;
    #1;
    chk("midrst_state", {27'b0, wt_addr_o_DIV, valid_o_DIV, busy_o_DIV, stall_o_DIV}, 32'd0);
    chk("midrst_result", result_o_DIV, 32'd0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i == 0) ? 32'd1 : $urandom >> $urandom_range(0, 28);
      do_op(1'(i % 2), 1'(i / 3), ra, rb, 5'(i + 1), i % 3, 1'b0, 1'b0);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_div_seq.md
Name: exe_div_seq

Overview:
- Sequencer for the multi-cycle divide resource attached to the EXE stage.
- Accepts one RV32M DIV/DIVU/REM/REMU request from EXE and stalls the pipeline while a radix-2 restoring divider iterates.
- Applies the RISC-V divide-by-zero and signed-overflow rules, then holds the result until EXE acknowledges it.
- Owns the iteration counter, the operand/sign registers and the stall request towards the pipeline control.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk_i_DIV  in  1  clock, rising edge.
- rst_i_DIV  in  1  synchronous, active-low reset (asserted when equal to `RstEnable = 1'b0).
- start_i_DIV  in  1  request; sampled only in IDLE.
- signed_i_DIV  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- rem_sel_i_DIV  in  1  0 = return quotient, 1 = return remainder.
- dividend_i_DIV  in  DATA_W  rs1 value.
- divisor_i_DIV  in  DATA_W  rs2 value.
- wt_addr_i_DIV  in  5  destination register.
- cancel_i_DIV  in  1  pipeline flush; aborts any operation.
- ack_i_DIV  in  1  EXE consumed the result.
- result_o_DIV  out  DATA_W  selected quotient or remainder.
- wt_addr_o_DIV  out  5  latched destination register.
- valid_o_DIV  out  1  result_o_DIV/wt_addr_o_DIV valid.
- busy_o_DIV  out  1  state != IDLE.
- stall_o_DIV  out  1  freeze IF/ID/EXE.

Behaviour:
Reset (synchronous, rst_i_DIV low at a rising edge):
- state = IDLE; counter = 0.
- result_o_DIV = `ZeroRegData, wt_addr_o_DIV = `ZeroRegAddr.
- valid_o_DIV = 0, busy_o_DIV = 0.
- Reset overrides all other inputs, including mid-operation.
- stall_o_DIV is forced to 0 while reset is asserted.

States IDLE, RUN, DONE:
- IDLE, start=1, cancel=0:
  - Latch wt_addr, rem_sel and sign info: neg_q = signed & (a[31]^b[31]); neg_r = signed & a[31].
  - Latch |a| and |b| (two's-complement magnitude when signed, raw value otherwise).
  - Divisor == 0 -> DONE next cycle with Q = all ones, R = dividend.
  - signed, a = 0x80000000, b = 0xFFFFFFFF -> DONE next cycle with Q = 0x80000000, R = 0.
  - Otherwise -> RUN with counter = 0, remainder accumulator = 0.
- RUN, one iteration per cycle:
  - Shift {rem, quo} left by one; trial = rem - |b| (DATA_W+1 bits).
  - If trial is non-negative, rem = trial and the quotient LSB = 1.
  - After DATA_W iterations (counter == DATA_W-1 at the edge), go to DONE.
  - Apply sign fix-up at the DONE entry: Q negated if neg_q, R negated if neg_r.
- DONE:
  - valid_o_DIV = 1; result_o_DIV = rem_sel ? R : Q.
  - Hold until ack_i_DIV = 1, then go to IDLE with valid = 0 the next cycle.
  - Outputs are stable while waiting for ack.

Latency:
- Normal operation: start edge, then 32 RUN cycles; valid rises 33 cycles after start is sampled.
- Special cases (divide-by-zero, signed overflow): valid rises 1 cycle after start.

Stall:
- stall_o_DIV = (state==IDLE & start & !cancel) | state==RUN | (state==DONE & !ack).
- Combinational, so the pipeline freezes in the same cycle start is presented.

Boundary and priority rules:
- cancel in any state -> IDLE next edge, valid = 0, result discarded. Cancel beats start and beats ack.
- start in RUN/DONE is ignored; requests are not queued.
- ack outside DONE is ignored.
- ack and start in the same cycle while in DONE: ack is accepted, start is ignored; EXE re-presents start after stall drops.
- Counter saturates at DATA_W-1 in RUN and never wraps past it.
- Unsigned operations never negate.

Decomposition:
- Add to define.v: `DivStateBus [1:0] and state encodings `DIV_IDLE = 2'd0, `DIV_RUN = 2'd1, `DIV_DONE = 2'd2.
- Also add to define.v: ALUOp codes `DIV, `DIVU, `REM, `REMU; existing `RstEnable, `ZeroRegData, `ZeroRegAddr are reused.
- One natural sub-module: div_iter_step, a combinational single restoring step: inputs {rem, quo}, |b|; outputs next {rem, quo}.

Test Plan:
- Unsigned 100/7: start with signed=0, rem_sel=0 -> stall high 34 cycles; valid at cycle 33; result = 14 (rem_sel=1 on rerun -> 2); wt_addr echoed.
- Signed -100/7: signed=1 -> Q = 0xFFFFFFF2 (-14), R = 0xFFFFFFFE (-2); 7/-2 -> Q = -3, R = 1.
- Divide-by-zero 0x1234/0: valid 1 cycle after start; Q = 0xFFFFFFFF, R = 0x1234. Signed 0x80000000/0xFFFFFFFF: Q = 0x80000000, R = 0.
- cancel at RUN cycle 10 -> IDLE next edge, valid never rises, stall low; a new start is then accepted and 20/3 = 6.
- Hold ack low 5 cycles in DONE: result stable, stall high; ack+start in the same cycle: returns to IDLE, start ignored; start while RUN ignored.
- rst_i_DIV low for 1 edge mid-RUN -> all outputs at reset values next cycle; cancel+start together in IDLE -> stays IDLE.
